// File: rtl/riscv_mem_arbiter.sv
// Round-robin two-master arbiter for the shared data-memory port (LSU = master 0, loader/debug = master 1).
// A grant is held until the memory completes, the watchdog expires, or the owner withdraws its request.
module riscv_mem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_be_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wd_i,
  output logic [31:0] m0_rd_o,
  output logic        m0_ready_o,
  output logic        m0_err_o,

  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_be_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wd_i,
  output logic [31:0] m1_rd_o,
  output logic        m1_ready_o,
  output logic        m1_err_o,

  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i
);

  localparam int unsigned WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WDW-1:0] WDOG_LAST = WDW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [WDW-1:0] WDOG_ONE  = WDW'(1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t         state_q, state_d;
  logic           owner_q, owner_d;
  logic           last_q, last_d;
  logic [WDW-1:0] wdog_q, wdog_d;

  logic own_req, oth_req, expire, done;

  assign own_req = owner_q ? m1_req_i : m0_req_i;
  assign oth_req = owner_q ? m0_req_i : m1_req_i;
  assign expire  = (TIMEOUT != 0) && !mem_ready_i && (wdog_q == WDOG_LAST);
  assign done    = mem_ready_i || expire;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      wdog_q  <= wdog_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    wdog_d     = wdog_q;
    mem_req_o  = 1'b0;
    mem_we_o   = 1'b0;
    mem_be_o   = 4'b0;
    mem_addr_o = 32'b0;
    mem_wd_o   = 32'b0;
    m0_rd_o    = 32'b0;
    m0_ready_o = 1'b0;
    m0_err_o   = 1'b0;
    m1_rd_o    = 32'b0;
    m1_ready_o = 1'b0;
    m1_err_o   = 1'b0;

    case (state_q)
      IDLE: begin
        wdog_d = '0;
        if (m0_req_i && m1_req_i) begin
          owner_d = ~last_q;
          state_d = BUSY;
        end else if (m0_req_i) begin
          owner_d = 1'b0;
          state_d = BUSY;
        end else if (m1_req_i) begin
          owner_d = 1'b1;
          state_d = BUSY;
        end
      end

      BUSY: begin
        // An owner that withdraws mid-access is dropped silently; fairness history is kept.
        if (!own_req) begin
          state_d = IDLE;
          wdog_d  = '0;
        end else begin
          mem_req_o  = 1'b1;
          mem_we_o   = owner_q ? m1_we_i   : m0_we_i;
          mem_be_o   = owner_q ? m1_be_i   : m0_be_i;
          mem_addr_o = owner_q ? m1_addr_i : m0_addr_i;
          mem_wd_o   = owner_q ? m1_wd_i   : m0_wd_i;
          if (done) begin
            if (owner_q) begin
              m1_ready_o = 1'b1;
              m1_rd_o    = mem_ready_i ? mem_rd_i : 32'b0;
              m1_err_o   = !mem_ready_i;
            end else begin
              m0_ready_o = 1'b1;
              m0_rd_o    = mem_ready_i ? mem_rd_i : 32'b0;
              m0_err_o   = !mem_ready_i;
            end
            last_d = owner_q;
            wdog_d = '0;
            // Hand straight over to a waiting master so alternating traffic has no idle bubble.
            if (oth_req) begin
              owner_d = ~owner_q;
            end else begin
              state_d = IDLE;
            end
          end else if (TIMEOUT != 0) begin
            wdog_d = wdog_q + WDOG_ONE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Scoreboard bench for riscv_mem_arbiter: stimulus pushes expected completions,
// a negedge monitor pops and compares them whenever a ready pulse appears.
module tb_riscv_mem_arbiter;

  logic        clk, rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [3:0]  m0_be, m1_be;
  logic [31:0] m0_addr, m0_wd, m1_addr, m1_wd;
  logic [31:0] m0_rd, m1_rd;
  logic        m0_ready, m0_err, m1_ready, m1_err;
  logic        mem_req, mem_we, mem_ready;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wd, mem_rd;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        master;
    logic [31:0] rd;
    logic        err;
  } exp_t;
  exp_t exp_q[$];

  int ws        = 0;
  bit mem_never = 1'b0;

  riscv_mem_arbiter #(.TIMEOUT(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_be_i(m0_be), .m0_addr_i(m0_addr), .m0_wd_i(m0_wd),
    .m0_rd_o(m0_rd), .m0_ready_o(m0_ready), .m0_err_o(m0_err),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_be_i(m1_be), .m1_addr_i(m1_addr), .m1_wd_i(m1_wd),
    .m1_rd_o(m1_rd), .m1_ready_o(m1_ready), .m1_err_o(m1_err),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_addr_o(mem_addr),
    .mem_wd_o(mem_wd), .mem_rd_i(mem_rd), .mem_ready_i(mem_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout got=running want=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=0x%08h want=0x%08h", name, act, exp);
    end
  endtask

  task automatic pushExp(input logic m, input logic [31:0] rd, input logic err);
    exp_t e;
    e.master = m;
    e.rd     = rd;
    e.err    = err;
    exp_q.push_back(e);
  endtask

  task automatic setMaster(input bit m, input logic req, input logic we, input logic [3:0] be,
                           input logic [31:0] addr, input logic [31:0] wd);
    if (m) begin
      m1_req = req; m1_we = we; m1_be = be; m1_addr = addr; m1_wd = wd;
    end else begin
      m0_req = req; m0_we = we; m0_be = be; m0_addr = addr; m0_wd = wd;
    end
  endtask

  // Holds a request through n completions, stepping the address between them.
  task automatic applyStimulus(input bit m, input logic we, input logic [3:0] be,
                               input logic [31:0] addr, input logic [31:0] wd,
                               input int n, input logic [31:0] step);
    logic [31:0] a;
    int waited;
    a = addr;
    @(posedge clk); #1;
    setMaster(m, 1'b1, we, be, a, wd);
    for (int i = 0; i < n; i++) begin
      waited = 0;
      @(negedge clk);
      while (!(m ? m1_ready : m0_ready) && waited < 40) begin
        @(negedge clk);
        waited++;
      end
      if (!(m ? m1_ready : m0_ready)) begin
        total++;
        bad++;
        $display("[TB] FAIL m%0d_ready_timeout got=0 want=1", m);
        setMaster(m, 1'b0, 1'b0, 4'b0, 32'b0, 32'b0);
        return;
      end
      @(posedge clk); #1;
      if (i == n - 1) begin
        setMaster(m, 1'b0, 1'b0, 4'b0, 32'b0, 32'b0);
      end else begin
        a = a + step;
        setMaster(m, 1'b1, we, be, a, wd);
      end
    end
  endtask

  task automatic resetDut();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Memory: answers after ws wait states; reads return a value derived from the address.
  initial begin
    int cnt;
    cnt = 0;
    mem_ready = 1'b0;
    mem_rd    = 32'b0;
    forever begin
      @(posedge clk); #2;
      if (!mem_req) begin
        cnt = 0;
        mem_ready = 1'b0;
        mem_rd    = 32'b0;
      end else if (mem_never) begin
        mem_ready = 1'b0;
        mem_rd    = 32'b0;
      end else if (cnt >= ws) begin
        cnt = 0;
        mem_ready = 1'b1;
        if (mem_we)
          mem_rd = 32'b0;
        else if (mem_addr == 32'h0000_0010)
          mem_rd = 32'hDEAD_BEEF;
        else
          mem_rd = {16'hC0DE, mem_addr[15:0]};
      end else begin
        cnt++;
        mem_ready = 1'b0;
        mem_rd    = 32'b0;
      end
    end
  end

  // Monitor: every ready pulse must match the oldest expected completion.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!m0_ready) checkOutput("m0_rd_quiet", m0_rd, 32'b0);
      if (!m1_ready) checkOutput("m1_rd_quiet", m1_rd, 32'b0);
      if (m0_ready && m1_ready) begin
        total++;
        bad++;
        $display("[TB] FAIL both_ready got=11 want=one");
      end else if (m0_ready || m1_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_ready got=m%0d want=none", m1_ready);
        end else begin
          e = exp_q.pop_front();
          checkOutput("sb_master", 32'(m1_ready), 32'(e.master));
          checkOutput("sb_rd", m1_ready ? m1_rd : m0_rd, e.rd);
          checkOutput("sb_err", 32'(m1_ready ? m1_err : m0_err), 32'(e.err));
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    setMaster(1'b0, 1'b0, 1'b0, 4'b0, 32'b0, 32'b0);
    setMaster(1'b1, 1'b0, 1'b0, 4'b0, 32'b0, 32'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
    checkOutput("rst_m0_ready", 32'(m0_ready), 32'd0);
    checkOutput("rst_m1_ready", 32'(m1_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    $display("[TB] single master 0 read, zero-wait");
    ws = 0;
    pushExp(1'b0, 32'hDEAD_BEEF, 1'b0);
    fork
      applyStimulus(1'b0, 1'b0, 4'hF, 32'h0000_0010, 32'b0, 1, 32'd0);
      begin
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("t1_idle_req", 32'(mem_req), 32'd0);
        @(negedge clk);
        checkOutput("t1_busy_req", 32'(mem_req), 32'd1);
        checkOutput("t1_addr", mem_addr, 32'h0000_0010);
        checkOutput("t1_m1_ready", 32'(m1_ready), 32'd0);
      end
    join

    $display("[TB] simultaneous requests, 2 wait states");
    resetDut();
    ws = 2;
    pushExp(1'b0, 32'hC0DE_0300, 1'b0);
    pushExp(1'b1, 32'h0000_0000, 1'b0);
    fork
      applyStimulus(1'b0, 1'b0, 4'hF, 32'h0000_0300, 32'b0, 1, 32'd0);
      applyStimulus(1'b1, 1'b1, 4'b1100, 32'h0000_0400, 32'hCAFE_F00D, 1, 32'd0);
      begin
        @(posedge clk); #1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("t2_m0_addr", mem_addr, 32'h0000_0300);
        checkOutput("t2_m0_we", 32'(mem_we), 32'd0);
        repeat (3) @(negedge clk);
        checkOutput("t2_handover_req", 32'(mem_req), 32'd1);
        checkOutput("t2_m1_addr", mem_addr, 32'h0000_0400);
        checkOutput("t2_m1_we", 32'(mem_we), 32'd1);
        checkOutput("t2_m1_be", 32'(mem_be), 32'h0000_000C);
        checkOutput("t2_m1_wd", mem_wd, 32'hCAFE_F00D);
      end
    join

    $display("[TB] both masters streaming, zero-wait");
    ws = 0;
    for (int i = 0; i < 4; i++) begin
      pushExp(1'b0, 32'hC0DE_0100 + 32'(4 * i), 1'b0);
      pushExp(1'b1, 32'hC0DE_0200 + 32'(4 * i), 1'b0);
    end
    fork
      applyStimulus(1'b0, 1'b0, 4'hF, 32'h0000_0100, 32'b0, 4, 32'd4);
      applyStimulus(1'b1, 1'b0, 4'hF, 32'h0000_0200, 32'b0, 4, 32'd4);
    join

    $display("[TB] watchdog expiry on master 1 write");
    mem_never = 1'b1;
    pushExp(1'b1, 32'h0000_0000, 1'b1);
    fork
      applyStimulus(1'b1, 1'b1, 4'b0011, 32'h0000_0500, 32'h1234_5678, 1, 32'd0);
      begin
        @(posedge clk); #1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("t4_we", 32'(mem_we), 32'd1);
        checkOutput("t4_be", 32'(mem_be), 32'h0000_0003);
        checkOutput("t4_addr", mem_addr, 32'h0000_0500);
        checkOutput("t4_wd", mem_wd, 32'h1234_5678);
        repeat (2) @(negedge clk);
        checkOutput("t4_no_early_ready", 32'(m1_ready), 32'd0);
        @(negedge clk);
        checkOutput("t4_err_cycle4", 32'(m1_err), 32'd1);
        @(negedge clk);
        checkOutput("t4_idle_after", 32'(mem_req), 32'd0);
      end
    join
    mem_never = 1'b0;

    $display("[TB] memory ready coincides with watchdog limit");
    ws = 3;
    pushExp(1'b0, 32'hC0DE_0900, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'hF, 32'h0000_0900, 32'b0, 1, 32'd0);

    $display("[TB] reset during wait state");
    ws = 5;
    @(posedge clk); #1;
    setMaster(1'b0, 1'b1, 1'b0, 4'hF, 32'h0000_0B00, 32'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    setMaster(1'b0, 1'b0, 1'b0, 4'b0, 32'b0, 32'b0);
    @(negedge clk);
    checkOutput("t5_req_after_rst", 32'(mem_req), 32'd0);
    checkOutput("t5_no_ready", 32'(m0_ready), 32'd0);
    ws = 0;
    pushExp(1'b0, 32'hC0DE_0600, 1'b0);
    pushExp(1'b1, 32'hC0DE_0700, 1'b0);
    fork
      applyStimulus(1'b0, 1'b0, 4'hF, 32'h0000_0600, 32'b0, 1, 32'd0);
      applyStimulus(1'b1, 1'b0, 4'hF, 32'h0000_0700, 32'b0, 1, 32'd0);
    join

    $display("[TB] owner withdraws request mid-access");
    ws = 5;
    pushExp(1'b1, 32'hC0DE_0800, 1'b0);
    fork
      begin
        @(posedge clk); #1;
        setMaster(1'b0, 1'b1, 1'b0, 4'hF, 32'h0000_0A00, 32'b0);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("t6_owner_req", 32'(mem_req), 32'd1);
        checkOutput("t6_owner_addr", mem_addr, 32'h0000_0A00);
        @(posedge clk); #1;
        setMaster(1'b0, 1'b0, 1'b0, 4'b0, 32'b0, 32'b0);
        ws = 0;
        @(negedge clk);
        checkOutput("t6_abort_req", 32'(mem_req), 32'd0);
        @(negedge clk);
        checkOutput("t6_idle_req", 32'(mem_req), 32'd0);
        @(negedge clk);
        checkOutput("t6_regrant_req", 32'(mem_req), 32'd1);
        checkOutput("t6_regrant_addr", mem_addr, 32'h0000_0800);
      end
      begin
        @(posedge clk);
        applyStimulus(1'b1, 1'b0, 4'hF, 32'h0000_0800, 32'b0, 1, 32'd0);
      end
    join

    repeat (3) @(negedge clk);
    checkOutput("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
